// File: rtl/e203_rst_seq.sv
// Reset sequencer: conditions board button and PLL lock, then releases reset domains
// in ascending order; supports software full reset and debug reset of a domain subset.
module e203_rst_seq #(
   parameter int unsigned         NUM_DOM     = 3,
   parameter int unsigned         SYNC_STAGES = 2,
   parameter int unsigned         EXT_DEB     = 4,
   parameter int unsigned         LOCK_HOLD   = 16,
   parameter int unsigned         DOM_GAP     = 8,
   parameter logic [NUM_DOM-1:0]  DBG_MASK    = ~NUM_DOM'(1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ext_rst_n_i,
   input  logic               locked_i,
   input  logic               sw_rst_req_i,
   input  logic               dbg_rst_req_i,
   output logic [NUM_DOM-1:0] dom_rst_o,
   output logic [NUM_DOM-1:0] dom_rst_n_o,
   output logic               busy_o,
   output logic [3:0]         rst_cause_o
);

   localparam int unsigned DCW = $clog2(EXT_DEB + 1);
   localparam int unsigned HCW = $clog2(LOCK_HOLD + 1);
   localparam int unsigned GCW = $clog2(DOM_GAP + 1);

   localparam logic [NUM_DOM-1:0] ALL_ONES  = '1;
   localparam logic [NUM_DOM-1:0] FIRST_REL = ALL_ONES & ~NUM_DOM'(1);

   localparam logic [3:0] CAUSE_EXT  = 4'b0001;
   localparam logic [3:0] CAUSE_LOCK = 4'b0010;
   localparam logic [3:0] CAUSE_SW   = 4'b0100;
   localparam logic [3:0] CAUSE_DBG  = 4'b1000;

   typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN, S_DBG} state_e;

   state_e               state_q, state_d;
   logic [SYNC_STAGES-1:0] ext_sync_q, lock_sync_q;
   logic [DCW-1:0]       dcnt_q, dcnt_d;
   logic [HCW-1:0]       hcnt_q, hcnt_d;
   logic [GCW-1:0]       gcnt_q, gcnt_d;
   logic [NUM_DOM-1:0]   dom_q, dom_d, dom_n_q, dom_clr;
   logic [3:0]           cause_q, cause_d;
   logic                 busy_q, busy_d;
   logic                 arm_q, arm_d;
   logic                 ext_s, lock_s, ext_ok, good, gcnt_hit;

   assign ext_s    = ext_sync_q[SYNC_STAGES-1];
   assign lock_s   = lock_sync_q[SYNC_STAGES-1];
   // Assert path is immediate; release path waits for the debounce count.
   assign ext_ok   = ext_s && (dcnt_q == DCW'(EXT_DEB));
   assign good     = ext_ok && lock_s;
   assign gcnt_hit = (gcnt_q == GCW'(DOM_GAP - 1));
   assign dom_clr  = dom_q & (dom_q - NUM_DOM'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_HOLD;
         ext_sync_q  <= '0;
         lock_sync_q <= '0;
         dcnt_q      <= '0;
         hcnt_q      <= '0;
         gcnt_q      <= '0;
         dom_q       <= ALL_ONES;
         dom_n_q     <= '0;
         cause_q     <= '0;
         busy_q      <= 1'b1;
         arm_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ext_sync_q  <= {ext_sync_q[SYNC_STAGES-2:0], ext_rst_n_i};
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked_i};
         dcnt_q      <= dcnt_d;
         hcnt_q      <= hcnt_d;
         gcnt_q      <= gcnt_d;
         dom_q       <= dom_d;
         dom_n_q     <= ~dom_d;
         cause_q     <= cause_d;
         busy_q      <= busy_d;
         arm_q       <= arm_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dom_d   = dom_q;
      cause_d = cause_q;
      hcnt_d  = '0;
      gcnt_d  = '0;
      arm_d   = 1'b0;
      dcnt_d  = dcnt_q;

      if (!ext_s)                         dcnt_d = '0;
      else if (dcnt_q != DCW'(EXT_DEB))   dcnt_d = dcnt_q + DCW'(1);

      if ((state_q != S_HOLD) && (!good || sw_rst_req_i)) begin
         state_d = S_HOLD;
         dom_d   = ALL_ONES;
         if (!ext_ok)       cause_d = CAUSE_EXT;
         else if (!lock_s)  cause_d = CAUSE_LOCK;
         else               cause_d = CAUSE_SW;
      end else begin
         unique case (state_q)
            S_HOLD: begin
               dom_d = ALL_ONES;
               if (good) begin
                  if (hcnt_q == HCW'(LOCK_HOLD - 1)) begin
                     dom_d   = FIRST_REL;
                     state_d = (FIRST_REL == '0) ? S_RUN : S_RELEASE;
                  end else begin
                     hcnt_d = hcnt_q + HCW'(1);
                  end
               end
            end
            S_RELEASE: begin
               if (gcnt_hit) begin
                  dom_d = dom_clr;
                  if (dom_clr == '0) state_d = S_RUN;
               end else begin
                  gcnt_d = gcnt_q + GCW'(1);
               end
            end
            S_RUN: begin
               dom_d = '0;
               if (dbg_rst_req_i && (DBG_MASK != '0)) begin
                  state_d = S_DBG;
                  cause_d = CAUSE_DBG;
               end
            end
            S_DBG: begin
               arm_d = 1'b1;
               // First DBG cycle asserts the masked domains, then they drain like RELEASE.
               if (!arm_q) begin
                  dom_d = dom_q | DBG_MASK;
               end else if (gcnt_hit) begin
                  dom_d = dom_clr;
                  if (dom_clr == '0) state_d = S_RUN;
               end else begin
                  gcnt_d = gcnt_q + GCW'(1);
               end
            end
            default: state_d = S_HOLD;
         endcase
      end

      busy_d = (state_d != S_RUN);
   end

   assign dom_rst_o   = dom_q;
   assign dom_rst_n_o = dom_n_q;
   assign busy_o      = busy_q;
   assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_e203_rst_seq.sv
// Directed bench for e203_rst_seq with default parameters; edge counts are absolute
// from the reset-deassertion edge (edge 0).
module tb_e203_rst_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       ext_rst_n_i;
   logic       locked_i;
   logic       sw_rst_req_i;
   logic       dbg_rst_req_i;
   logic [2:0] dom_rst_o;
   logic [2:0] dom_rst_n_o;
   logic       busy_o;
   logic [3:0] rst_cause_o;

   int n_tests = 0;
   int n_fail  = 0;
   int e       = 0;

   e203_rst_seq dut (
      .clk          (clk),
      .reset        (reset),
      .ext_rst_n_i  (ext_rst_n_i),
      .locked_i     (locked_i),
      .sw_rst_req_i (sw_rst_req_i),
      .dbg_rst_req_i(dbg_rst_req_i),
      .dom_rst_o    (dom_rst_o),
      .dom_rst_n_o  (dom_rst_n_o),
      .busy_o       (busy_o),
      .rst_cause_o  (rst_cause_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", tag, e, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      e++;
   endtask

   task automatic run_to(input int target);
      while (e < target) tick();
   endtask

   initial begin
      int k;
      int t;
      logic [2:0] exp_dom;

      reset = 1'b1; ext_rst_n_i = 1'b1; locked_i = 1'b1;
      sw_rst_req_i = 1'b0; dbg_rst_req_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dom",   32'(dom_rst_o),   32'h7);
      check("rst_dom_n", 32'(dom_rst_n_o), 32'h0);
      check("rst_busy",  32'(busy_o),      32'h1);
      check("rst_cause", 32'(rst_cause_o), 32'h0);
      reset = 1'b0; e = 0;

      // power-up release: 22, 30, 38
      run_to(21); check("pu_21", 32'(dom_rst_o), 32'h7);
      tick();     check("pu_22", 32'(dom_rst_o), 32'h6);
      check("pu_cause", 32'(rst_cause_o), 32'h0);
      run_to(29); check("pu_29", 32'(dom_rst_o), 32'h6);
      tick();     check("pu_30", 32'(dom_rst_o), 32'h4);
      run_to(37); check("pu_37", 32'(dom_rst_o), 32'h4);
      check("pu_busy37", 32'(busy_o), 32'h1);
      tick();     check("pu_38", 32'(dom_rst_o), 32'h0);
      check("pu_busy38", 32'(busy_o), 32'h0);
      check("pu_dom_n",  32'(dom_rst_n_o), 32'h7);

      // lock drop in RUN: asserts 3 edges later, then 16-edge requalification
      k = e;
      locked_i = 1'b0; tick(); locked_i = 1'b1;
      tick();  check("lk_p2", 32'(dom_rst_o), 32'h0);
      tick();  check("lk_p3", 32'(dom_rst_o), 32'h7);
      check("lk_cause", 32'(rst_cause_o), 32'h2);
      check("lk_busy",  32'(busy_o), 32'h1);
      run_to(k + 18); check("lk_rel_pre", 32'(dom_rst_o), 32'h7);
      tick();         check("lk_rel0",    32'(dom_rst_o), 32'h6);
      run_to(k + 35); check("lk_run",     32'(dom_rst_o), 32'h0);
      check("lk_busy_run", 32'(busy_o), 32'h0);

      // 2-cycle button pulse in RUN: full requalification
      k = e;
      ext_rst_n_i = 1'b0; tick(); tick(); ext_rst_n_i = 1'b1;
      check("bt_p2", 32'(dom_rst_o), 32'h0);
      tick(); check("bt_p3", 32'(dom_rst_o), 32'h7);
      check("bt_cause", 32'(rst_cause_o), 32'h1);
      run_to(k + 23); check("bt_rel_pre", 32'(dom_rst_o), 32'h7);
      tick();         check("bt_rel0",    32'(dom_rst_o), 32'h6);
      run_to(k + 40); check("bt_run",     32'(dom_rst_o), 32'h0);
      check("bt_busy", 32'(busy_o), 32'h0);

      // debug reset with default mask
      dbg_rst_req_i = 1'b1; tick(); dbg_rst_req_i = 1'b0;
      t = e;
      check("dbg_t",     32'(dom_rst_o),   32'h0);
      check("dbg_cause", 32'(rst_cause_o), 32'h8);
      check("dbg_busy",  32'(busy_o),      32'h1);
      for (int i = 1; i <= 17; i++) begin
         tick();
         exp_dom = (i < 9) ? 3'b110 : (i < 17) ? 3'b100 : 3'b000;
         check($sformatf("dbg_t+%0d", i), 32'(dom_rst_o), 32'(exp_dom));
      end
      check("dbg_busy_end",  32'(busy_o),      32'h0);
      check("dbg_cause_end", 32'(rst_cause_o), 32'h8);

      // sw reset during DBG
      dbg_rst_req_i = 1'b1; tick(); dbg_rst_req_i = 1'b0;
      t = e;
      run_to(t + 4);
      sw_rst_req_i = 1'b1; tick(); sw_rst_req_i = 1'b0;
      check("swd_dom",   32'(dom_rst_o),   32'h7);
      check("swd_cause", 32'(rst_cause_o), 32'h4);
      run_to(t + 20); check("swd_rel_pre", 32'(dom_rst_o), 32'h7);
      tick();         check("swd_rel0",    32'(dom_rst_o), 32'h6);
      run_to(t + 37); check("swd_run",     32'(dom_rst_o), 32'h0);

      // simultaneous sw+dbg in RUN: sw wins
      sw_rst_req_i = 1'b1; dbg_rst_req_i = 1'b1; tick();
      sw_rst_req_i = 1'b0; dbg_rst_req_i = 1'b0;
      t = e;
      check("swdbg_dom",   32'(dom_rst_o),   32'h7);
      check("swdbg_cause", 32'(rst_cause_o), 32'h4);

      // sw in HOLD and dbg in RELEASE are ignored
      run_to(t + 4);
      sw_rst_req_i = 1'b1; tick(); sw_rst_req_i = 1'b0;
      check("swhold_cause", 32'(rst_cause_o), 32'h4);
      run_to(t + 15); check("swhold_pre", 32'(dom_rst_o), 32'h7);
      tick();         check("swhold_rel", 32'(dom_rst_o), 32'h6);
      run_to(t + 19);
      dbg_rst_req_i = 1'b1; tick(); dbg_rst_req_i = 1'b0;
      check("dbgrel_cause", 32'(rst_cause_o), 32'h4);
      check("dbgrel_dom",   32'(dom_rst_o),   32'h6);
      run_to(t + 24); check("dbgrel_step", 32'(dom_rst_o), 32'h4);

      // async reset mid-RELEASE, no clock edge
      reset = 1'b1;
      #2;
      check("ar_dom",   32'(dom_rst_o),   32'h7);
      check("ar_dom_n", 32'(dom_rst_n_o), 32'h0);
      check("ar_busy",  32'(busy_o),      32'h1);
      check("ar_cause", 32'(rst_cause_o), 32'h0);

      // lock bounce at hold count 10: first release at 33
      @(posedge clk); #1;
      reset = 1'b0; e = 0;
      run_to(14);
      locked_i = 1'b0; tick(); locked_i = 1'b1;
      run_to(32); check("lb_32", 32'(dom_rst_o), 32'h7);
      tick();     check("lb_33", 32'(dom_rst_o), 32'h6);
      check("lb_cause", 32'(rst_cause_o), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
